// File: rtl/handshake_initiator_pkg.sv
// Shared definitions for the request/accept/done handshake family:
// state encoding, timer width and the default timeout.
package handshake_initiator_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned TIMER_W         = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_DONE = 2'b10,
        ERR       = 2'b11
    } hs_state_e;

endpackage

// File: rtl/handshake_initiator_if.sv
// Upstream job port plus request/accept/done link between an initiator
// (master) and a responder-side user (slave).
interface handshake_initiator_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start_valid;
    logic              start_ready;
    logic [DATA_W-1:0] start_data;
    logic              request;
    logic [DATA_W-1:0] req_data;
    logic              accept;
    logic              done;

    modport master (
        input  start_valid, start_data, accept, done,
        output start_ready, request, req_data
    );

    modport slave (
        output start_valid, start_data, accept, done,
        input  start_ready, request, req_data
    );
endinterface

// File: rtl/handshake_timer.sv
// Per-phase wait counter: clears on request, counts while enabled and
// flags the last permitted cycle (count == TIMEOUT-1).
module handshake_timer
    import handshake_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/handshake_initiator.sv
// Requester side of the request/accept/done handshake: one job at a time,
// per-phase timeout abort and a wrapping completed-transaction counter.
module handshake_initiator
    import handshake_initiator_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    handshake_initiator_if.master hs,
    output logic                  busy,
    output logic                  complete,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      txn_count
);

    hs_state_e         state_q;
    hs_state_e         state_d;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_expired_c;

    logic [DATA_W-1:0] req_data_q;
    logic [DATA_W-1:0] req_data_d;
    logic              complete_q;
    logic              complete_d;
    logic              timeout_err_q;
    logic              timeout_err_d;
    logic [CNT_W-1:0]  txn_count_q;
    logic [CNT_W-1:0]  txn_count_d;

    handshake_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_c (timer_expired_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Events (accept / done) take priority over the timeout on the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hs.start_valid) state_d = REQ;
            end
            REQ: begin
                if (hs.accept)           state_d = WAIT_DONE;
                else if (timer_expired_c) state_d = ERR;
            end
            WAIT_DONE: begin
                if (hs.done)             state_d = IDLE;
                else if (timer_expired_c) state_d = ERR;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hs.start_ready = (state_q == IDLE);
        hs.request     = (state_q == REQ);
        hs.req_data    = req_data_q;
        busy           = (state_q != IDLE);
        complete       = complete_q;
        timeout_err    = timeout_err_q;
        txn_count      = txn_count_q;

        timer_clr      = (state_d != state_q);
        timer_en       = (state_q == REQ) || (state_q == WAIT_DONE);

        req_data_d     = req_data_q;
        if ((state_q == IDLE) && hs.start_valid) begin
            req_data_d = hs.start_data;
        end
        complete_d     = (state_q == WAIT_DONE) && hs.done;
        timeout_err_d  = (state_d == ERR);
        txn_count_d    = complete_d ? (txn_count_q + CNT_W'(1)) : txn_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_data_q    <= '0;
            complete_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            txn_count_q   <= '0;
        end else begin
            req_data_q    <= req_data_d;
            complete_q    <= complete_d;
            timeout_err_q <= timeout_err_d;
            txn_count_q   <= txn_count_d;
        end
    end

endmodule

// File: tb/tb_handshake_initiator.sv
// Directed bench for handshake_initiator (CNT_W=2 to exercise counter wrap).
module tb_handshake_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       complete;
    logic       timeout_err;
    logic [1:0] txn_count;

    int checks   = 0;
    int failures = 0;

    handshake_initiator_if #(.DATA_W(8)) hs ();

    handshake_initiator #(
        .DATA_W  (8),
        .TIMEOUT (16),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hs          (hs),
        .busy        (busy),
        .complete    (complete),
        .timeout_err (timeout_err),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job against a compliant responder; entered in the cycle before the
    // start edge, returns in the completion cycle (cycle 5).
    task automatic job(input logic [7:0] d, input logic [7:0] nxt,
                       input logic keep_valid, input logic [1:0] exp_cnt);
        hs.start_valid = 1'b1;
        hs.start_data  = d;
        chk("job_ready_c0", 8'(hs.start_ready), 8'd1);
        tick();
        hs.start_valid = keep_valid;
        hs.start_data  = nxt;
        chk("job_req_c1", 8'(hs.request), 8'd1);
        chk("job_data_c1", hs.req_data, d);
        chk("job_ready_c1", 8'(hs.start_ready), 8'd0);
        tick();
        chk("job_req_c2", 8'(hs.request), 8'd1);
        chk("job_ready_c2", 8'(hs.start_ready), 8'd0);
        hs.accept = 1'b1;
        tick();
        chk("job_req_c3", 8'(hs.request), 8'd0);
        chk("job_busy_c3", 8'(busy), 8'd1);
        chk("job_ready_c3", 8'(hs.start_ready), 8'd0);
        tick();
        hs.accept = 1'b0;
        hs.done   = 1'b1;
        chk("job_cmpl_c4", 8'(complete), 8'd0);
        chk("job_ready_c4", 8'(hs.start_ready), 8'd0);
        tick();
        hs.done = 1'b0;
        chk("job_cmpl_c5", 8'(complete), 8'd1);
        chk("job_ready_c5", 8'(hs.start_ready), 8'd1);
        chk("job_cnt_c5", 8'(txn_count), 8'(exp_cnt));
        chk("job_data_c5", hs.req_data, d);
    endtask

    initial begin
        rst            = 1'b0;
        hs.start_valid = 1'b0;
        hs.start_data  = 8'h00;
        hs.accept      = 1'b0;
        hs.done        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 8'(hs.start_ready), 8'd1);
        chk("rst_request", 8'(hs.request), 8'd0);
        chk("rst_req_data", hs.req_data, 8'h00);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_complete", 8'(complete), 8'd0);
        chk("rst_timeout", 8'(timeout_err), 8'd0);
        chk("rst_cnt", 8'(txn_count), 8'd0);
        rst = 1'b1;
        tick();

        // Single job
        job(8'hA5, 8'h00, 1'b0, 2'd1);
        tick();
        chk("single_cmpl_pulse", 8'(complete), 8'd0);
        chk("single_busy", 8'(busy), 8'd0);
        chk("single_data_hold", hs.req_data, 8'hA5);

        // Back-to-back with valid held, continuing into counter wrap
        rst = 1'b0;
        tick();
        rst = 1'b1;
        job(8'h01, 8'h02, 1'b1, 2'd1);
        job(8'h02, 8'h03, 1'b1, 2'd2);
        job(8'h03, 8'h04, 1'b1, 2'd3);
        job(8'h04, 8'h05, 1'b1, 2'd0);
        job(8'h05, 8'h00, 1'b0, 2'd1);
        tick();
        chk("b2b_idle_busy", 8'(busy), 8'd0);
        chk("b2b_idle_cmpl", 8'(complete), 8'd0);

        // Accept timeout: request held 16 cycles, then ERR pulse
        hs.start_valid = 1'b1;
        hs.start_data  = 8'h3C;
        tick();
        hs.start_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("acc_to_request", 8'(hs.request), 8'd1);
            chk("acc_to_no_err", 8'(timeout_err), 8'd0);
            tick();
        end
        chk("acc_to_req_drop", 8'(hs.request), 8'd0);
        chk("acc_to_err", 8'(timeout_err), 8'd1);
        chk("acc_to_busy_err", 8'(busy), 8'd1);
        chk("acc_to_no_cmpl", 8'(complete), 8'd0);
        tick();
        chk("acc_to_err_pulse", 8'(timeout_err), 8'd0);
        chk("acc_to_busy_drop", 8'(busy), 8'd0);
        chk("acc_to_ready", 8'(hs.start_ready), 8'd1);
        chk("acc_to_cnt", 8'(txn_count), 8'd1);
        chk("acc_to_data_hold", hs.req_data, 8'h3C);

        // Done timeout: 16 cycles in WAIT_DONE
        hs.start_valid = 1'b1;
        hs.start_data  = 8'h5A;
        tick();
        hs.start_valid = 1'b0;
        tick();
        hs.accept = 1'b1;
        tick();
        hs.accept = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("done_to_wait_req", 8'(hs.request), 8'd0);
            chk("done_to_wait_busy", 8'(busy), 8'd1);
            chk("done_to_no_err", 8'(timeout_err), 8'd0);
            tick();
        end
        chk("done_to_err", 8'(timeout_err), 8'd1);
        chk("done_to_no_cmpl", 8'(complete), 8'd0);
        tick();
        chk("done_to_busy_drop", 8'(busy), 8'd0);
        chk("done_to_cnt", 8'(txn_count), 8'd1);

        // Race: done on the last permitted WAIT_DONE cycle
        hs.start_valid = 1'b1;
        hs.start_data  = 8'h66;
        tick();
        hs.start_valid = 1'b0;
        tick();
        hs.accept = 1'b1;
        tick();
        hs.accept = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        chk("race_still_busy", 8'(busy), 8'd1);
        hs.done = 1'b1;
        tick();
        hs.done = 1'b0;
        chk("race_cmpl", 8'(complete), 8'd1);
        chk("race_no_err", 8'(timeout_err), 8'd0);
        chk("race_cnt", 8'(txn_count), 8'd2);
        tick();
        chk("race_after_err", 8'(timeout_err), 8'd0);

        // Reset while in WAIT_DONE, then a late done
        hs.start_valid = 1'b1;
        hs.start_data  = 8'h99;
        tick();
        hs.start_valid = 1'b0;
        tick();
        hs.accept = 1'b1;
        tick();
        hs.accept = 1'b0;
        chk("midrst_in_wait", 8'(busy), 8'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_request", 8'(hs.request), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_cmpl", 8'(complete), 8'd0);
        chk("midrst_err", 8'(timeout_err), 8'd0);
        chk("midrst_cnt", 8'(txn_count), 8'd0);
        chk("midrst_data", hs.req_data, 8'h00);
        hs.done = 1'b1;
        tick();
        hs.done = 1'b0;
        chk("late_done_cmpl", 8'(complete), 8'd0);
        chk("late_done_cnt", 8'(txn_count), 8'd0);
        chk("late_done_busy", 8'(busy), 8'd0);

        // Protocol violation: done during REQ is ignored
        hs.start_valid = 1'b1;
        hs.start_data  = 8'h77;
        tick();
        hs.start_valid = 1'b0;
        hs.done        = 1'b1;
        tick();
        hs.done = 1'b0;
        chk("viol_still_req", 8'(hs.request), 8'd1);
        chk("viol_no_cmpl", 8'(complete), 8'd0);
        chk("viol_cnt", 8'(txn_count), 8'd0);
        hs.accept = 1'b1;
        tick();
        hs.accept = 1'b0;
        hs.done   = 1'b1;
        chk("viol_wait", 8'(hs.request), 8'd0);
        tick();
        hs.done = 1'b0;
        chk("viol_cmpl", 8'(complete), 8'd1);
        chk("viol_cnt_after", 8'(txn_count), 8'd1);
        chk("viol_data", hs.req_data, 8'h77);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_initiator.md
Name: handshake_initiator

Overview:
Requester side of the request/accept/done handshake used by the existing responder controller. Takes one job at a time from an upstream valid/ready port and holds its data. Drives `request` until `accept` is seen, then releases `request` and waits for the one-cycle `done` pulse. Adds per-phase timeout detection and a completed-transaction counter, and sits between the datapath sequencer and any responder-style unit.

Parameters:
DATA_W, 8, width of the job payload forwarded on req_data
TIMEOUT, 16, max cycles spent in a wait state before aborting (legal range 2..255)
CNT_W, 8, width of the completed-transaction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low (0 = reset at next rising clk edge)
start_valid  input  1  upstream job available
start_ready  output  1  initiator can take a job
start_data  input  DATA_W  job payload
request  output  1  request to responder
req_data  output  DATA_W  latched payload, stable while busy
accept  input  1  responder accepting
done  input  1  responder one-cycle completion pulse
busy  output  1  transaction in flight (state != IDLE)
complete  output  1  one-cycle pulse, transaction finished normally
timeout_err  output  1  one-cycle pulse, transaction aborted by timeout
txn_count  output  CNT_W  number of normally completed transactions

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, request=0, req_data=0, complete=0, timeout_err=0, txn_count=0, timer=0.
  - Applies from any state, including mid-transaction; the responder sees request drop the following cycle.
- States, encoded in 2 bits: IDLE, REQ, WAIT_DONE, ERR.
- Output decode:
  - start_ready = (state==IDLE).
  - request = (state==REQ).
  - busy = (state!=IDLE).
  - complete and timeout_err are registered pulses.
- IDLE:
  - On start_valid & start_ready, latch start_data into req_data and go to REQ.
  - start_data is otherwise ignored.
- REQ:
  - If accept=1, go to WAIT_DONE, so request deasserts the next cycle.
  - done while in REQ is a protocol violation and is ignored.
- WAIT_DONE:
  - If done=1, go to IDLE, set complete=1 for one cycle, and increment txn_count in the same edge.
  - accept is ignored here; the responder still shows accept for one more cycle.
  - If accept and done are both high, done wins.
- ERR: timeout_err=1 for exactly one cycle, request=0, then go to IDLE. txn_count is unchanged.
- Timer:
  - Cleared on every state change and counts cycles in REQ or WAIT_DONE.
  - When the timer reaches TIMEOUT-1 with no qualifying event, the next state is ERR.
  - An event (accept in REQ, done in WAIT_DONE) on that same cycle wins over the timeout.
- txn_count wraps modulo 2^CNT_W with no saturation.
- Latency against a compliant responder, with the start handshake at edge E0:
  - request high cycles 1–2.
  - accept seen cycles 2–3.
  - request low from cycle 3.
  - done in cycle 4.
  - complete and start_ready=1 in cycle 5, so back-to-back jobs run every 5 cycles.
- req_data holds its value until the next job is accepted; it is not cleared on completion or timeout.

Decomposition:
- Shared header `include: state encodings (IDLE=2'b00, REQ=2'b01, WAIT_DONE=2'b10, ERR=2'b11) and the default TIMEOUT constant, reused by the responder bench and future handshake blocks.
- One natural sub-module: handshake_timer, an 8-bit counter with clear and enable and an `expired` flag at TIMEOUT-1. The FSM, payload register and txn counter stay in handshake_initiator.

Test Plan:
- Single job, paired with the responder: start_data=8'hA5, one cycle of start_valid -> request cycles 1–2, complete in cycle 5, txn_count=1, req_data=A5 throughout.
- Back-to-back: start_valid held high with 3 jobs (01, 02, 03) -> start_ready high only in cycles 0, 5, 10; complete in cycles 5, 10, 15; txn_count=3.
- Accept timeout: accept tied 0, TIMEOUT=16 -> request high 16 cycles, then ERR with timeout_err pulse; busy drops next cycle, txn_count unchanged, no complete.
- Done timeout plus race: accept given but done withheld -> timeout_err after 16 cycles in WAIT_DONE. Then a run with done asserted exactly on timer=15 -> complete=1, timeout_err=0.
- Reset mid-operation: assert rst=0 for one edge while in WAIT_DONE -> all outputs 0 next cycle, txn_count=0. A late done pulse afterwards is ignored.
- Wrap and violation: CNT_W=2, run 5 jobs -> txn_count sequence 1, 2, 3, 0, 1. Inject done during REQ -> ignored, FSM still waits for accept.
